// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle. The states are IDLE (waiting for start), CALC (one bit per edge) and FIX (sign fix-up, write result, pulse done).
module muldiv_unit #(
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flush,
  input  logic [2:0]    funct3,
  input  logic [WL-1:0] operand1,
  input  logic [WL-1:0] operand2,
  output logic          busy,
  output logic          done,
  output logic [WL-1:0] result
);

  localparam int CW = $clog2(WL) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic [WL-1:0]   dvs_q, dvs_d;
  logic [2*WL-1:0] acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [WL-1:0]   result_q, result_d;

  logic            signed1, signed2, s1, s2;
  logic [WL-1:0]   mag1, mag2;
  logic            div_zero, div_ovf;
  logic [WL:0]     mul_sum, rem_sh, trial;
  logic [2*WL-1:0] prod;
  logic [WL-1:0]   quot, rem, fix_res;

  // Multiplies treat funct3 11 as unsigned-unsigned; divides use bit 0 as the unsigned flag.
  assign signed1  = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign signed2  = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign s1       = signed1 & operand1[WL-1];
  assign s2       = signed2 & operand2[WL-1];
  assign mag1     = s1 ? -operand1 : operand1;
  assign mag2     = s2 ? -operand2 : operand2;
  assign div_zero = funct3[2] && (operand2 == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (operand1 == {1'b1, {(WL-1){1'b0}}})
                    && (operand2 == '1);

  assign mul_sum = {1'b0, acc_q[2*WL-1:WL]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign rem_sh  = acc_q[2*WL-1:WL-1];
  assign trial   = rem_sh - {1'b0, dvs_q};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -acc_q[WL-1:0] : acc_q[WL-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*WL-1:WL] : acc_q[2*WL-1:WL];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod[WL-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*WL-1:WL];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dvs_d     = dvs_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d   = funct3;
          busy_d = 1'b1;
          if (div_zero) begin
            // Special results are preloaded into the accumulator so FIX needs no extra path.
            acc_d     = {operand1, {WL{1'b1}}};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_FIX;
          end else if (div_ovf) begin
            acc_d     = {{WL{1'b0}}, operand1};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_FIX;
          end else begin
            acc_d     = {{WL{1'b0}}, funct3[2] ? mag1 : mag2};
            dvs_d     = funct3[2] ? mag2 : mag1;
            neg_d     = s1 ^ s2;
            neg_rem_d = s1;
            cnt_d     = CW'(WL);
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          if (!op_q[2]) begin
            acc_d = {mul_sum, acc_q[WL-1:1]};
          end else if (!trial[WL]) begin
            acc_d = {trial[WL-1:0], acc_q[WL-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WL-1:0], acc_q[WL-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!flush) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dvs_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dvs_q     <= dvs_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus a per-cycle monitor of busy/done/result.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.WL(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } pend_t;

  pend_t       q[$];
  logic [31:0] last_res = '0;
  int          last_e = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic, RV32M special cases handled explicitly.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000: begin p = sa * sb; pv = p; return pv[31:0]; end
      3'b001: begin p = sa * sb; pv = p; return pv[63:32]; end
      3'b010: begin p = sa * ub; pv = p; return pv[63:32]; end
      3'b011: begin pv = {32'b0, a} * {32'b0, b}; return pv[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; pv = p; return pv[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; pv = p; return pv[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; pv = p; return pv[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; pv = p; return pv[31:0];
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Per-cycle compare of outputs against the pending-operation queue.
  always @(negedge clk) begin
    if (rst) begin
      logic exp_busy, exp_done;
      exp_busy = (q.size() > 0) && (cyc < q[0].done_cyc);
      exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        chk("result", result, q[0].res);
        last_res = q[0].res;
        void'(q.pop_front());
      end else begin
        chk("result_hold", result, last_res);
      end
    end
  end

  task automatic issue_now(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    pend_t e;
    funct3 = f; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
    last_e     = cyc;
    e.res      = model(f, a, b);
    e.done_cyc = cyc + latency(f, a, b);
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(f, a, b);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d ops outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_lit(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
    chk({"model_", name}, model(f, a, b), lit);
    issue(f, a, b);
    wait_idle();
    chk(name, result, lit);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[] = '{
    '{3'b000, 32'h0000_0000, 32'h1234_5678},
    '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'b001, 32'h7FFF_FFFF, 32'h8000_0000},
    '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF},
    '{3'b011, 32'h1234_5678, 32'h9ABC_DEF0},
    '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE},
    '{3'b100, 32'h8000_0000, 32'h0000_0001},
    '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001},
    '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE},
    '{3'b111, 32'h0000_0005, 32'h0000_0000},
    '{3'b101, 32'h0000_0003, 32'h0000_0009},
    '{3'b111, 32'hFFFF_FFFF, 32'h0001_0000}
  };

  initial begin
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_lit("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_lit("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_lit("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_lit("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_lit("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_lit("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_lit("divu",   3'b101, 32'd100,       32'd7,         32'd14);
    run_lit("remu",   3'b111, 32'd100,       32'd7,         32'd2);
    run_lit("divu_z", 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_lit("rem_z",  3'b110, 32'd5,         32'd0,         32'd5);
    run_lit("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_lit("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_idle();
    end

    // start with new operands at edge 10 of a running op must be ignored
    issue(3'b000, 32'd1000, 32'd3);
    wait_cyc(last_e + 9);
    funct3 = 3'b101; operand1 = 32'd77; operand2 = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk("ignored_start", result, 32'd3000);

    // back-to-back: second start during the done cycle
    issue(3'b101, 32'd1000, 32'd10);
    wait_cyc(last_e + 33);
    chk("b2b_first_done", {31'b0, done}, 32'd1);
    issue_now(3'b111, 32'd1001, 32'd10);
    wait_idle();
    chk("b2b_second", result, 32'd1);

    // flush at edge 5 of a DIVU
    issue(3'b101, 32'd100, 32'd7);
    wait_cyc(last_e + 4);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    q.delete();
    chk("flush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_result", result, 32'd1);

    // flush together with start in IDLE: not accepted
    @(negedge clk);
    funct3 = 3'b000; operand1 = 32'd9; operand2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // asynchronous reset mid-CALC
    issue(3'b011, 32'hFFFF_FFFF, 32'h0000_0003);
    wait_cyc(last_e + 10);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    q.delete();
    last_res = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(3'b101, 32'd100, 32'd7);
    wait_idle();
    chk("post_reset", result, 32'd14);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over a parametrised word length. It sits beside the single-cycle ALU in the datapath and is the multi-cycle, handshaked successor to it: the controller issues an operation with `start`, stalls the PC while `busy` is high, and writes `result` back through the result mux when `done` pulses. One bit is processed per cycle: shift-add for multiply, restoring division for divide.

## Interface

- `WL`, default 32: operand and result width. Legal range is WL ≥ 4.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Accepted only in IDLE.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `funct3`  in  3  operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand1`  in  WL  rs1 value (multiplicand/dividend). Sampled only at the accepting edge.
- `operand2`  in  WL  rs2 value (multiplier/divisor). Sampled only at the accepting edge.
- `busy`  out  1  operation in flight. Reset value 0.
- `done`  out  1  one-cycle pulse signalling that `result` is valid. Reset value 0.
- `result`  out  WL  registered result. Holds until the next `done`. Reset value 0.

## Operation

- FSM states: IDLE, CALC, FIX.
- **IDLE**
  - With `start`=1 at an edge, latch `funct3`, the operand magnitudes and the sign flags.
  - Load the iteration counter (width $clog2(WL)+1) with WL.
  - Go to CALC.
  - Exception: divide by zero or signed overflow goes directly to FIX.
- **CALC**, one iteration per edge; the counter decrements and reaching 0 moves the FSM to FIX.
  - Multiply: 2·WL-bit accumulator. If the multiplier LSB is 1, add the multiplicand to the upper half, then shift right 1.
  - Divide: shift the remainder:quotient pair left 1 and trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit 1; otherwise quotient bit 0.
- **FIX**, one edge. Apply the sign correction, write `result`, pulse `done`, and return to IDLE.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: operand1 signed, operand2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Signed operands are converted to magnitudes. A product is negated if the operand signs differ. A quotient is negated if the signs differ. A remainder takes the dividend's sign.
- Result select: MUL returns product[WL-1:0]; MULH* return product[2WL-1:WL]; DIV* return the quotient; REM* return the remainder.
- Special cases, with no CALC phase:
  - Divisor = 0: quotient = all ones; remainder = operand1.
  - DIV/REM with operand1 = 2^(WL-1) and operand2 = all ones: quotient = operand1; remainder = 0.
- `flush`:
  - In CALC/FIX: return to IDLE at the next edge. No `done`; `result` unchanged.
  - Has priority over `start`. `flush` and `start` together in IDLE means the start is not accepted.
- `start` while `busy`=1 is ignored; the in-flight operation is unaffected.
- `rst` low at any time: FSM to IDLE, counter 0, `busy`/`done`/`result` to 0 immediately. The in-flight operation is lost.

## Timing

- Edge 0 is the edge that accepts `start`.
- `busy` rises after edge 0. It is high throughout CALC and FIX and falls at the same edge that raises `done`.
- Normal operation: CALC covers edges 1..WL and FIX is edge WL+1. `done` and the new `result` are visible after edge WL+1, i.e. 33 edges at WL=32.
- Special case: FIX at edge 1. `done` is visible after edge 1.
- `done` is high for exactly one cycle. A `start` asserted during the `done` cycle is accepted (FSM is in IDLE), giving back-to-back throughput of WL+2 cycles per operation.
- Operand inputs may change freely after edge 0.

## Test plan

- **Reset:** `rst` low mid-CALC → `busy`=0, `done`=0, `result`=0 asynchronously. After release, the unit is in IDLE and the next `start` completes normally.
- **Multiply (WL=32):**
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, `done` after edge 33.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- **Special cases:** each has `done` after edge 1.
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- **Handshake:**
  - `start` with new operands at edge 10 of a running op → ignored; the original result is unchanged.
  - `start` during the `done` cycle → second op accepted, `done` again WL+2 cycles later.
- **Flush:**
  - `flush` at edge 5 of DIVU → no `done`; `result` keeps its previous value; `busy`=0 after that edge.
  - `flush`+`start` together in IDLE → not accepted.
